mem_access_unit: RTL and testbench

- Load/store front end that sits directly upstream of the 256x32 word RAM and is its only master.
- Owns the RAM's addr/data/wre pins, including the bidirectional data bus.
- Accepts byte-addressed load/store requests from the CPU datapath (byte, halfword, word) with signed or unsigned loads.
- Performs read-modify-write for sub-word stores, because the RAM is word-write only.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end and sole master of a 256x32 word RAM; sub-word stores are read-modify-write.
// Latency accept->resp: load and word store 2 cycles, sub-word store 3; misaligned trap 1 (MEMU_MISALIGN_TRAP_EN).
// Backpressure: req_ready only in IDLE with one request in flight; no response backpressure, resp_valid is a pulse.
module mem_access_unit #(
  parameter int RAM_AW = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [RAM_AW+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [RAM_AW-1:0] ram_addr,
  inout  wire  [31:0]       ram_data,
  output logic              ram_wre
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } hdr_t;

  state_t            state_q, state_d;
  hdr_t              hdr_q;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic [31:0]       load_dat;
  logic [31:0]       merge_dat;
  logic [7:0]        byte_dat;
  logic [15:0]       half_dat;
  logic              accept;
  logic              misalign;

  assign accept = req_valid && req_ready;

`ifdef MEMU_MISALIGN_TRAP_EN
  logic err_q;

  assign misalign = (req_size == 2'b01) ? req_addr[0]
                                        : (req_size[1] && (req_addr[1:0] != 2'b00));
  assign resp_err = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Word stores (size 10 and the reserved 11) skip the read; everything else reads first.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_wre    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misalign) begin
            state_d = RESP;
          end else if (req_write && req_size[1]) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = hdr_q.write ? WRITE : RESP;
      end
      WRITE: begin
        ram_wre = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    byte_dat  = ram_data[{hdr_q.lane, 3'b000} +: 8];
    half_dat  = hdr_q.lane[1] ? ram_data[31:16] : ram_data[15:0];
    load_dat  = ram_data;
    merge_dat = ram_data;
    case (hdr_q.size)
      2'b00: begin
        load_dat = {{24{!hdr_q.uns && byte_dat[7]}}, byte_dat};
        merge_dat[{hdr_q.lane, 3'b000} +: 8] = word_q[7:0];
      end
      2'b01: begin
        load_dat = {{16{!hdr_q.uns && half_dat[15]}}, half_dat};
        if (hdr_q.lane[1]) begin
          merge_dat[31:16] = word_q[15:0];
        end else begin
          merge_dat[15:0] = word_q[15:0];
        end
      end
      default: begin
        load_dat = ram_data;
      end
    endcase
  end

  // The RAM read is combinational, so ram_data is sampled on the edge that ends READ.
  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        hdr_q   <= '{write: req_write, size: req_size, uns: req_unsigned, lane: req_addr[1:0]};
        addr_q  <= req_addr[RAM_AW+1:2];
        word_q  <= req_wdata;
        rdata_q <= '0;
      end else if (state_q == READ) begin
        if (hdr_q.write) begin
          word_q <= merge_dat;
        end else begin
          rdata_q <= load_dat;
        end
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign ram_addr   = addr_q;
  // Drive enable and write enable share one state decode, so the bus is released whenever ram_wre is low.
  assign ram_data   = ram_wre ? word_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset-abort sequence, randomized traffic vs a reference model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  ram_addr;
  logic        ram_wre;
  wire  [31:0] ram_data;

  logic [31:0] mem   [256];
  logic [31:0] model [256];
  logic        init_we = 1'b0;
  logic [7:0]  init_a = '0;
  logic [31:0] init_d = '0;

  int passed = 0;
  int total  = 0;

  mem_access_unit #(.RAM_AW(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wre(ram_wre)
  );

  always #5 clock = ~clock;

  // RAM device: combinational read onto the bus while not written, synchronous word write.
  assign ram_data = ram_wre ? 32'hzzzz_zzzz : mem[ram_addr];
  always @(posedge clock) begin
    if (ram_wre) mem[ram_addr] <= ram_data;
    else if (init_we) mem[init_a] <= init_d;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [9:0] a);
`ifdef MEMU_MISALIGN_TRAP_EN
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    return (sz == 2'b11) && (a == 10'h3ff) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic uns, input logic [9:0] a);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (word >> (8 * a[1:0])) & 32'hff;
      if (!uns && v >= 32'h80) v = v + 32'hffff_ff00;
    end else if (sz == 2'b01) begin
      v = (word >> (16 * a[1])) & 32'hffff;
      if (!uns && v >= 32'h8000) v = v + 32'hffff_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input logic [31:0] word, input logic [1:0] sz,
                                            input logic [9:0] a, input logic [31:0] wd);
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * a[1:0];
      return (word & ~(32'hff << sh)) | ((wd & 32'hff) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * a[1];
      return (word & ~(32'hffff << sh)) | ((wd & 32'hffff) << sh);
    end
    return wd;
  endfunction

  // Issue one request, then watch up to 8 cycles; lat counts falling edges from accept to resp_valid and stays 0 if no response arrives.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns, input logic [9:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int wc, output logic [31:0] wword, output logic [7:0] waddr);
    int n;
    bit got;
    rd = '0; er = 1'b0; lat = 0; wc = 0; wword = '0; waddr = '0; got = 0;
    @(negedge clock);
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = 10'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clock);
      if (ram_wre) begin
        wc++;
        wword = ram_data;
        waddr = ram_addr;
      end
      if (resp_valid) begin
        got = 1;
        lat = c;
        rd = resp_rdata;
        er = resp_err;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd, ww;
    logic [7:0]  wa;
    logic        er;
    int          lat, wc, seen;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'hdeadbeef, 32'h0,         2, 1'b0, 32'hdeadbeef};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hdeadbeef,  2, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 10'h012, 32'haaaaaa55, 32'h0,         3, 1'b0, 32'hde55beef};
    tbl[3]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hde55beef,  2, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 10'h010, 32'h0,        32'hffffffef,  2, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 2'b01, 1'b1, 10'h012, 32'h0,        32'h0000de55,  2, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 2'b01, 1'b0, 10'h012, 32'h0,        32'hffffde55,  2, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 2'b00, 1'b1, 10'h013, 32'h0,        32'h000000de,  2, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 10'h010, 32'h0,        32'hde55beef,  2, 1'b0, 32'h0};
`ifdef MEMU_MISALIGN_TRAP_EN
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 10'h011, 32'h0,        32'h0,         1, 1'b1, 32'h0};
`else
    tbl[9]  = '{1'b0, 2'b10, 1'b0, 10'h011, 32'h0,        32'hde55beef,  2, 1'b0, 32'h0};
`endif
    tbl[10] = '{1'b1, 2'b00, 1'b0, 10'h013, 32'h12345680, 32'h0,         3, 1'b0, 32'h8055beef};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 10'h013, 32'h0,        32'hffffff80,  2, 1'b0, 32'h0};

    // Preload RAM and model with identical random contents while the DUT is held in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      init_we = 1'b1;
      init_a  = 8'(i);
      init_d  = $urandom;
      model[i] = init_d;
    end
    @(negedge clock);
    init_we = 1'b0;
    chk("reset req_ready", req_ready, 1);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    chk("reset resp_err", resp_err, 0);
    chk("reset ram_wre", ram_wre, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("ram preload", mem[200], model[200]);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_req(tbl[i].w, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat, wc, ww, wa);
      chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d err", i), er, tbl[i].exp_err);
      chk($sformatf("tbl%0d latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d wre cycles", i), wc, tbl[i].w ? 1 : 0);
      if (tbl[i].w) begin
        chk($sformatf("tbl%0d bus word", i), ww, tbl[i].exp_mem);
        chk($sformatf("tbl%0d ram[4]", i), mem[4], tbl[i].exp_mem);
        model[4] = tbl[i].exp_mem;
      end
    end
    chk("neighbour ram[5] untouched", mem[5], model[5]);

    // Reset lands in the READ cycle of a byte store: access aborted, nothing written, no response.
    @(negedge clock);
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 10'h010;
    req_wdata = 32'h11; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("mid read wre", ram_wre, 0);
    chk("mid read addr", ram_addr, 8'h04);
    reset = 1'b1;
    @(negedge clock);
    chk("abort req_ready", req_ready, 1);
    chk("abort ram_wre", ram_wre, 0);
    chk("abort ram_addr", ram_addr, 0);
    chk("abort resp_valid", resp_valid, 0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 0) chk("ready after release", req_ready, 1);
      if (resp_valid || ram_wre) seen++;
    end
    chk("abort no activity", seen, 0);
    chk("abort ram[4] kept", mem[4], 32'h8055beef);

    // Randomized traffic over words 0..7 against the reference model.
    for (int k = 0; k < 150; k++) begin
      logic        w, uns;
      logic [1:0]  sz;
      logic [9:0]  a;
      logic [31:0] wd, exp_rd, nw;
      logic [7:0]  wi;
      bit          mis;
      int          exp_lat, exp_wc;
      w   = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      a   = 10'($urandom_range(0, 31));
      wd  = $urandom;
      wi  = 8'(a >> 2);
      mis = is_mis(sz, a);
      exp_rd  = (w || mis) ? 32'h0 : exp_load(model[wi], sz, uns, a);
      nw      = exp_store(model[wi], sz, a, wd);
      exp_lat = mis ? 1 : ((w && sz[1] == 1'b0) ? 3 : 2);
      exp_wc  = (w && !mis) ? 1 : 0;
      run_req(w, sz, uns, a, wd, rd, er, lat, wc, ww, wa);
      chk($sformatf("rnd%0d rdata", k), rd, exp_rd);
      chk($sformatf("rnd%0d err", k), er, 32'(mis));
      chk($sformatf("rnd%0d latency", k), lat, exp_lat);
      chk($sformatf("rnd%0d wre cycles", k), wc, exp_wc);
      if (exp_wc == 1) begin
        model[wi] = nw;
        chk($sformatf("rnd%0d bus word", k), ww, nw);
        chk($sformatf("rnd%0d bus addr", k), wa, wi);
        chk($sformatf("rnd%0d ram word", k), mem[wi], model[wi]);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
